// File: rtl/sparc_ifu_swsched.sv
// sparc_ifu_swsched: per-thread switch scheduler for the 4-thread IFU.
// Picks one eligible thread per cycle (round-robin after the last issued
// thread) and parks any thread that issues a switch-hinted instruction
// until its completion pulse arrives.
// Optional feature macro: IFU_SWSCHED_STALLCNT_EN adds one saturating
// per-thread wait counter, readable through swl_stall_cnt_o.
module sparc_ifu_swsched #(
  parameter int NTHR = 4,
  parameter int CNTW = 16
) (
  input  logic            rclk,
  input  logic            reset,
  input  logic [NTHR-1:0] swl_thr_rdy_i,
  input  logic [NTHR-1:0] swl_sw_hint_i,
  input  logic [NTHR-1:0] swl_thr_done_i,
  input  logic            dec_stall_i,
  input  logic            swl_cnt_clr_i,
  input  logic [1:0]      swl_cnt_idx_i,
  output logic [NTHR-1:0] swl_thr_sel_o,
  output logic            swl_issue_vld_o,
  output logic [NTHR-1:0] swl_thr_wait_o,
  output logic [CNTW-1:0] swl_stall_cnt_o
);

  typedef enum logic {ST_RUN = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t          r_st     [NTHR];
  state_t          w_st_nxt [NTHR];
  logic [1:0]      r_lp;
  logic [NTHR-1:0] r_sel;
  logic            r_vld;

  logic [NTHR-1:0] w_wait;
  logic [NTHR-1:0] w_elig;
  logic            w_issue;
  logic [1:0]      w_win;
  logic [1:0]      w_cand;
  logic            w_found;

  // Decode the per-thread state into the WAIT vector.
  always_comb begin
    w_wait = '0;
    for (int t = 0; t < NTHR; t++) begin
      w_wait[t] = (r_st[t] == ST_WAIT);
    end
  end

  assign w_elig  = swl_thr_rdy_i & ~w_wait;
  assign w_issue = ~dec_stall_i & (|w_elig);

  // Round-robin search starting just after the last issued thread.
  always_comb begin
    w_win   = r_lp;
    w_cand  = '0;
    w_found = 1'b0;
    for (int i = 1; i <= NTHR; i++) begin
      w_cand = r_lp + 2'(i);
      if (!w_found && w_elig[w_cand]) begin
        w_win   = w_cand;
        w_found = 1'b1;
      end
    end
  end

  // Next state for each thread: park on a hinted issue, release on done.
  always_comb begin
    for (int t = 0; t < NTHR; t++) begin
      w_st_nxt[t] = r_st[t];
      case (r_st[t])
        ST_RUN:  if (w_issue && (w_win == 2'(t)) && swl_sw_hint_i[t]) w_st_nxt[t] = ST_WAIT;
        ST_WAIT: if (swl_thr_done_i[t]) w_st_nxt[t] = ST_RUN;
        default: w_st_nxt[t] = ST_RUN;
      endcase
    end
  end

  // Thread state registers; reset discards any pending WAIT.
  always_ff @(posedge rclk) begin
    for (int t = 0; t < NTHR; t++) begin
      if (reset) r_st[t] <= ST_RUN;
      else       r_st[t] <= w_st_nxt[t];
    end
  end

  // Issue registers; a decode stall freezes selection and pointer.
  always_ff @(posedge rclk) begin
    if (reset) begin
      r_sel <= '0;
      r_vld <= 1'b0;
      r_lp  <= 2'd3;
    end else if (!dec_stall_i) begin
      if (w_issue) begin
        r_sel <= NTHR'(1) << w_win;
        r_vld <= 1'b1;
        r_lp  <= w_win;
      end else begin
        r_sel <= '0;
        r_vld <= 1'b0;
      end
    end
  end

  assign swl_thr_sel_o   = r_sel;
  assign swl_issue_vld_o = r_vld;
  assign swl_thr_wait_o  = w_wait;

`ifdef IFU_SWSCHED_STALLCNT_EN
  logic [CNTW-1:0] r_cnt [NTHR];

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Wait-cycle counters: clear wins over increment, saturate at all-ones.
  always_ff @(posedge rclk) begin
    for (int t = 0; t < NTHR; t++) begin
      if (reset || swl_cnt_clr_i) r_cnt[t] <= '0;
      else if (w_wait[t])         r_cnt[t] <= sat_inc(r_cnt[t]);
    end
  end

  assign swl_stall_cnt_o = r_cnt[swl_cnt_idx_i];
`else
  logic w_unused;
  assign w_unused        = &{1'b0, swl_cnt_clr_i, swl_cnt_idx_i};
  assign swl_stall_cnt_o = '0;
`endif

endmodule
